// File: rtl/key_input_pkg.sv
// Shared types, default timing constants and sizing helper for the push-button conditioner.
package key_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } key_state_e;

  localparam int unsigned DEF_TICK_DIV       = 10000;
  localparam int unsigned DEF_DEBOUNCE_TICKS = 20;
  localparam int unsigned DEF_LONG_TICKS     = 1000;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// One key's debounce state machine with registered level/press/release outputs.
// Define KEY_LONG_PRESS_EN to add the hold counter and long-press pulse.
module key_debounce_fsm
  import key_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int unsigned LONG_TICKS     = DEF_LONG_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  if (DEBOUNCE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_params
    $error("key_debounce_fsm: DEBOUNCE_TICKS and LONG_TICKS must be >= 1");
  end

  localparam int unsigned      CW       = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (raw_i) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        // A level change beats a coincident tick: abandon without counting.
        if (!raw_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HELD: begin
        if (!raw_i) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (raw_i) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (tick_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned   HW        = cnt_width(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_TICKS);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Saturating at LONG_TICKS guarantees a single long pulse per accepted press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_q == PRESS_WAIT && state_d == HELD) begin
      hold_d = '0;
    end else if (tick_i && (state_q == HELD || state_q == RELEASE_WAIT) && hold_q != HOLD_SAT) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_q == HOLD_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_o = long_q;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/key_input_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, shared ms-tick prescaler, one debounce FSM per key.
// Define KEY_LONG_PRESS_EN to enable the per-key long-press pulse on key_long.
module key_input_conditioner
  import key_input_pkg::*;
#(
  parameter int unsigned N_KEYS         = 2,
  parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int unsigned LONG_TICKS     = DEF_LONG_TICKS
) (
  input  logic              ADC_CLK_10,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              tick
);

  if (TICK_DIV < 2) begin : g_bad_params
    $error("key_input_conditioner: TICK_DIV must be >= 2");
  end

  localparam int unsigned   DW       = cnt_width(TICK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [DW-1:0]     div_q, div_d;

  // NOTE: synchronizer flops reset to the released value so a reset never fabricates a press.
  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~key_n;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = (div_q == DIV_LAST);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LONG_TICKS     (LONG_TICKS)
    ) u_fsm (
      .clk       (ADC_CLK_10),
      .rst       (rst),
      .tick_i    (tick),
      .raw_i     (sync2_q[k]),
      .level_o   (key_level[k]),
      .press_o   (key_press[k]),
      .release_o (key_release[k]),
      .long_o    (key_long[k])
    );
  end

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with an event scoreboard (expected pulse cycle and vectors).
`timescale 1ns/1ps
module tb_key_input_conditioner;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int LONG     = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key_n = 2'b11;
  logic [1:0] key_level, key_press, key_release, key_long;
  logic       tick;

  always #50 clk = ~clk;

  key_input_conditioner #(
    .N_KEYS         (2),
    .TICK_DIV       (TICK_DIV),
    .DEBOUNCE_TICKS (DEB),
    .LONG_TICKS     (LONG)
  ) dut (
    .ADC_CLK_10  (clk),
    .rst         (rst),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .tick        (tick)
  );

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_mis = 0;
  int  cyc;
  int  long_seen = 0;

  // Cycle 1 is the cycle in which reset is released; sampled at negedge, current cycle = cyc + 1.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int now_cyc();
    return cyc + 1;
  endfunction

  // Cycle just after the k-th tick cycle at or after 'start' (ticks fall in cycles divisible by TICK_DIV).
  function automatic int after_nth_tick(input int start, input int k);
    int c;
    int seen;
    c    = start;
    seen = 0;
    while (seen < k) begin
      if (c % TICK_DIV == 0) seen++;
      c++;
    end
    return c;
  endfunction

  // Input changed in cycle n: raw_s settles in n+2, the wait state is entered in n+3.
  function automatic int pulse_cycle(input int n);
    return after_nth_tick(n + 3, DEB);
  endfunction

  task automatic push_ev(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
    exp_q.push_back('{c, p, r, l});
  endtask

  task automatic wait_until(input int c);
    while (now_cyc() < c) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (key_long[1]) long_seen++;
      if ((key_press | key_release | key_long) != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'({key_long, key_release, key_press}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", 32'(now_cyc()), 32'(e.cyc));
          check("event_press", 32'(key_press), 32'(e.press));
          check("event_release", 32'(key_release), 32'(e.rel));
          check("event_long", 32'(key_long), 32'(e.lng));
        end
      end
    end
  end

  initial begin
    int n;
    int m;
    int t;
    int p;

    // Reset and prescaler phase.
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({key_level, key_press, key_release, key_long, tick}), 32'd0);
    rst = 1'b0;
    check("post_rst_outputs", 32'({key_level, key_press, key_release, key_long}), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("tick_phase", 32'(tick), 32'(now_cyc() % TICK_DIV == 0));
      @(negedge clk);
    end

    // Clean press then release on key 0.
    key_n = 2'b10;
    n = now_cyc();
    push_ev(pulse_cycle(n), 2'b01, 2'b00, 2'b00);
    wait_drain(20);
    check("level_after_press", 32'(key_level), 32'd1);
    key_n = 2'b11;
    n = now_cyc();
    push_ev(pulse_cycle(n), 2'b00, 2'b01, 2'b00);
    wait_drain(20);
    check("level_after_release", 32'(key_level), 32'd0);

    // Press with a one-cycle bounce after the first debounce tick: count restarts from the last edge.
    key_n = 2'b10;
    n = now_cyc();
    t = after_nth_tick(n + 3, 1) - 1;
    m = t + 1;
    wait_until(m);
    key_n = 2'b11;
    @(negedge clk);
    key_n = 2'b10;
    n = now_cyc();
    push_ev(pulse_cycle(n), 2'b01, 2'b00, 2'b00);
    wait_drain(30);
    check("level_after_bounce_press", 32'(key_level), 32'd1);

    // Release with a one-tick low glitch inside the release window: no press, one release.
    key_n = 2'b11;
    repeat (6) @(negedge clk);
    key_n = 2'b10;
    repeat (TICK_DIV) @(negedge clk);
    key_n = 2'b11;
    m = now_cyc();
    push_ev(pulse_cycle(m), 2'b00, 2'b01, 2'b00);
    wait_drain(30);
    check("level_after_glitch_release", 32'(key_level), 32'd0);

    // Both keys together, then reset while held.
    key_n = 2'b00;
    n = now_cyc();
    push_ev(pulse_cycle(n), 2'b11, 2'b00, 2'b00);
    wait_drain(20);
    check("level_both_held", 32'(key_level), 32'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", 32'({key_level, key_press, key_release, key_long, tick}), 32'd0);
    key_n = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("level_after_mid_rst", 32'(key_level), 32'd0);

    // Long hold on key 1 for 20 ticks.
    key_n = 2'b01;
    n = now_cyc();
    p = pulse_cycle(n);
    push_ev(p, 2'b10, 2'b00, 2'b00);
`ifdef KEY_LONG_PRESS_EN
    push_ev(after_nth_tick(p, LONG), 2'b00, 2'b00, 2'b10);
`endif
    wait_drain(70);
    wait_until(p + 20 * TICK_DIV);
    check("level_long_hold", 32'(key_level), 32'd2);
    key_n = 2'b11;
    n = now_cyc();
    push_ev(pulse_cycle(n), 2'b00, 2'b10, 2'b00);
    wait_drain(20);
`ifdef KEY_LONG_PRESS_EN
    check("long_pulse_count", 32'(long_seen), 32'd1);
`else
    check("long_pulse_count", 32'(long_seen), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
